mac_seq_ctrl: RTL and testbench

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl.sv | 86 ++++++++
 tb/tb_mac_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// Sequenced multiply-accumulate controller: takes a job of 1..16 operand
// pairs, accumulates a*b into an ACC_W-bit register and presents the result.
module mac_seq_ctrl #(
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [ACC_W-1:0] r_acc;
    logic [4:0]       r_count;
    logic             r_ovf;

    logic             w_accept;
    logic             w_lastBeat;
    logic [7:0]       w_prod;
    logic [ACC_W:0]   w_sum;
    logic [4:0]       w_jobLen;

    assign w_prod     = a * b;
    assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - 8){1'b0}}, w_prod};
    assign w_jobLen   = (len == 4'd0) ? 5'd16 : {1'b0, len};
    assign w_accept   = in_valid && (r_state == S_RUN);
    assign w_lastBeat = w_accept && (r_count == 5'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // start is only looked at in IDLE, so a start during a DONE handshake is dropped
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (start)      w_nextState = S_RUN;
            S_RUN:  if (w_lastBeat) w_nextState = S_DONE;
            S_DONE: if (res_ready)  w_nextState = S_IDLE;
            default:                w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_acc   <= '0;
            r_count <= w_jobLen;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_sum[ACC_W-1:0];
            r_count <= r_count - 5'd1;
            r_ovf   <= r_ovf | w_sum[ACC_W];
        end
    end

    assign in_ready  = (r_state == S_RUN);
    assign res_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign result    = r_acc;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed scenarios plus randomized
// jobs compared against a plain-arithmetic sum-of-products model.
module tb_mac_seq_ctrl;

    localparam int ACC_W = 8;
    localparam int MOD   = 1 << ACC_W;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       len;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       a;
    logic [3:0]       b;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] result;
    logic             ovf;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int total;

    mac_seq_ctrl #(.ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .res_valid(res_valid), .res_ready(res_ready), .result(result),
        .ovf(ovf), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic start_job(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        len   = $urandom_range(0, 15);
        total = 0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || res_valid !== 1'b0 || result !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_job: busy=%b in_ready=%b res_valid=%b result=%0d ovf=%b, required 1 1 0 0 0",
                     busy, in_ready, res_valid, result, ovf);
        end
    endtask

    task automatic send_beat(input logic [3:0] ai, input logic [3:0] bi);
        int n = 0;
        in_valid = 1'b1;
        a = ai;
        b = bi;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_beat_timeout: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        total += ai * bi;
    endtask

    task automatic check_result(input string name, input logic expValid);
        logic [ACC_W-1:0] expRes;
        logic             expOvf;
        expRes = ACC_W'(total % MOD);
        expOvf = (total >= MOD);
        checks++;
        if (result !== expRes || ovf !== expOvf || res_valid !== expValid || in_ready !== !expValid) begin
            errors++;
            $display("[TB] FAIL %s: result=%0d ovf=%b res_valid=%b in_ready=%b, required %0d %b %b %b",
                     name, result, ovf, res_valid, in_ready, expRes, expOvf, expValid, !expValid);
        end
    endtask

    task automatic finish_job(input string name);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle: busy=%b res_valid=%b in_ready=%b, required 0 0 0",
                     name, busy, res_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) begin
            start     = $urandom_range(0, 1);
            len       = $urandom_range(0, 15);
            in_valid  = $urandom_range(0, 1);
            a         = $urandom_range(0, 15);
            b         = $urandom_range(0, 15);
            res_ready = $urandom_range(0, 1);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || res_valid !== 1'b0 || result !== '0 || ovf !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset: in_ready=%b res_valid=%b result=%0d ovf=%b busy=%b, required all 0",
                         in_ready, res_valid, result, ovf, busy);
            end
        end
        start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        start_job(4'd3);
        send_beat(4'd2, 4'd3);
        send_beat(4'd4, 4'd5);
        check_result("basic_mid", 1'b0);
        send_beat(4'd1, 4'd15);
        check_result("basic_done", 1'b1);
        checks++;
        if (result !== 8'd41) begin
            errors++;
            $display("[TB] FAIL basic_41: result=%0d, required 41", result);
        end
        finish_job("basic");
    endtask

    task automatic test_wrap();
        start_job(4'd2);
        send_beat(4'd15, 4'd15);
        send_beat(4'd15, 4'd15);
        checks++;
        if (result !== 8'd194 || ovf !== 1'b1 || res_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap: result=%0d ovf=%b res_valid=%b, required 194 1 1", result, ovf, res_valid);
        end
        finish_job("wrap");
    endtask

    task automatic test_stall();
        start_job(4'd4);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                @(negedge clk);
                check_result("stall_gap", 1'b0);
            end
            send_beat(4'd1, 4'd1);
        end
        repeat (5) begin
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (result !== 8'd4 || res_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold: result=%0d res_valid=%b busy=%b, required 4 1 1", result, res_valid, busy);
            end
        end
        in_valid = 1'b0;
        start = 1'b1;
        len   = 4'd2;
        finish_job("stall");
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_in_handshake: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_len0();
        start_job(4'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check_result("len0_before_last", 1'b0);
            send_beat(4'd1, 4'd1);
        end
        check_result("len0_done", 1'b1);
        in_valid = 1'b1;
        a = 4'd5;
        b = 4'd5;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (result !== 8'd16 || res_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL len0_beat17: result=%0d res_valid=%b, required 16 1", result, res_valid);
        end
        finish_job("len0");
    endtask

    task automatic test_abort();
        start_job(4'd5);
        send_beat(4'd2, 4'd2);
        send_beat(4'd3, 4'd1);
        start = 1'b1;
        len   = 4'd1;
        @(negedge clk);
        start = 1'b0;
        check_result("abort_start_in_run", 1'b0);
        send_beat(4'd1, 4'd2);
        check_result("abort_no_reload", 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || result !== '0 || in_ready !== 1'b0 || res_valid !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_async_reset: busy=%b result=%0d in_ready=%b res_valid=%b ovf=%b, required all 0",
                     busy, result, in_ready, res_valid, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_job(4'd1);
        send_beat(4'd3, 4'd3);
        checks++;
        if (result !== 8'd9 || res_valid !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_new_job: result=%0d res_valid=%b ovf=%b, required 9 1 0", result, res_valid, ovf);
        end
        finish_job("abort");
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            int l;
            l = $urandom_range(0, 15);
            start_job(4'(l));
            for (int i = 0; i < ((l == 0) ? 16 : l); i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                check_result("random_beat", 1'b0);
                send_beat(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
            check_result("random_done", 1'b1);
            finish_job("random");
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        a = '0; b = '0; res_ready = 1'b0; total = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_len0();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
